// File: rtl/pdu_uart_rx_pkg.sv
// Shared definitions for the PDU host-link receiver: register map,
// STATUS/CTRL bit positions, receive FSM states and the sample vote.
package pdu_uart_rx_pkg;

  // Register offsets, decoded from interface_addr[3:2]
  localparam logic [1:0] REG_RX_DATA = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;

  // STATUS bit positions
  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAME_ERR = 3;
  localparam int STAT_COUNT_LSB = 8;

  // CTRL bit positions
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FLUSH  = 1;

  // 16x oversampling: samples 7..9 straddle mid-bit, 15 closes the bit
  localparam logic [3:0] SAMPLE_VOTE_FIRST = 4'd7;
  localparam logic [3:0] SAMPLE_VOTE_LAST  = 4'd9;
  localparam logic [3:0] SAMPLE_LAST       = 4'd15;
  localparam logic [2:0] BIT_LAST          = 3'd7;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  // 2-of-3 majority of the mid-bit samples
  function automatic logic vote3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/pdu_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and a synchronous flush.
// A push into a full FIFO is accepted only when a pop retires the head on
// the same edge; otherwise it is dropped and the caller flags the overrun.
module pdu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush overrides any push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage array, written only for accepted pushes
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pdu_uart_rx.sv
// Receive half of the PDU host link: 8N1 deserialiser with 16x oversampling
// and 2-of-3 mid-bit vote, RX FIFO, and the interface_* register port.
module pdu_uart_rx
  import pdu_uart_rx_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int FIFO_AW   = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        uart_rxd,
  input  logic [31:0] interface_addr,
  output logic [31:0] interface_rdata,
  input  logic [31:0] interface_wdata,
  input  logic        interface_we,
  input  logic        interface_re
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_RELOAD = TW'(DIV - 1);
  localparam logic [TW-1:0] TICK_ONE    = TW'(1);

  logic              sync_p0;
  logic              sync_p1;
  logic [TW-1:0]     tick_cnt;
  logic              os_tick;
  rx_state_t         state;
  rx_state_t         state_nxt;
  logic [3:0]        samp_cnt;
  logic [2:0]        samp_v;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              at_last;
  logic              vote;
  logic              push_req;
  logic              frame_evt;
  logic              enable_q;
  logic              overrun_q;
  logic              frame_err_q;
  logic [1:0]        reg_sel;
  logic              wr_status;
  logic              wr_ctrl;
  logic              flush;
  logic              pop_req;
  logic              overrun_set;
  logic [7:0]        fifo_rdata;
  logic [FIFO_AW:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       status_word;
  logic              unused_bits;

  assign reg_sel     = interface_addr[3:2];
  assign wr_status   = interface_we && (reg_sel == REG_STATUS);
  assign wr_ctrl     = interface_we && (reg_sel == REG_CTRL);
  assign flush       = wr_ctrl && interface_wdata[CTRL_FLUSH];
  assign pop_req     = interface_re && (reg_sel == REG_RX_DATA);
  assign os_tick     = (tick_cnt == '0);
  assign at_last     = os_tick && (samp_cnt == SAMPLE_LAST);
  assign vote        = vote3(samp_v);
  // A full FIFO always holds a head byte, so a pop request frees a slot
  assign overrun_set = push_req && fifo_full && !pop_req && !flush;
  assign unused_bits = ^{interface_addr[31:4], interface_addr[1:0], interface_wdata[31:4]};

  // Two-flop synchroniser on the asynchronous line, idle-high reset
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= uart_rxd;
      sync_p1 <= sync_p0;
    end
  end

  // Oversample tick divider, held at reload while idle so a frame's
  // first tick lands DIV cycles after the start edge is seen
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                     tick_cnt <= TICK_RELOAD;
    else if (state == RX_IDLE || os_tick) tick_cnt <= TICK_RELOAD;
    else                                tick_cnt <= tick_cnt - TICK_ONE;
  end

  // Receive FSM next state and per-frame push / framing-error events
  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    frame_evt = 1'b0;
    if (!enable_q) begin
      state_nxt = RX_IDLE;
    end else begin
      case (state)
        RX_IDLE:  if (!sync_p1) state_nxt = RX_START;
        RX_START: if (at_last) state_nxt = vote ? RX_IDLE : RX_DATA;
        RX_DATA:  if (at_last && bit_cnt == BIT_LAST) state_nxt = RX_STOP;
        RX_STOP: begin
          if (at_last) begin
            if (vote) begin
              push_req  = 1'b1;
              state_nxt = RX_IDLE;
            end else begin
              frame_evt = 1'b1;
              state_nxt = RX_BREAK;
            end
          end
        end
        RX_BREAK: if (sync_p1) state_nxt = RX_IDLE;
        default:  state_nxt = RX_IDLE;
      endcase
    end
  end

  // FSM state, sample/bit counters, vote samples and LSB-first shifter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= RX_IDLE;
      samp_cnt <= '0;
      samp_v   <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state <= state_nxt;
      if (state == RX_IDLE) begin
        samp_cnt <= '0;
        bit_cnt  <= '0;
      end else if (os_tick) begin
        samp_cnt <= samp_cnt + 4'd1;
        if (samp_cnt >= SAMPLE_VOTE_FIRST && samp_cnt <= SAMPLE_VOTE_LAST)
          samp_v <= {sync_p1, samp_v[2:1]};
        if (samp_cnt == SAMPLE_LAST && state == RX_DATA) begin
          shreg   <= {vote, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

  // CTRL enable and sticky error flags; a new event beats a W1C clear
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      enable_q    <= 1'b1;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (wr_ctrl) enable_q <= interface_wdata[CTRL_ENABLE];
      overrun_q   <= overrun_set |
                     (overrun_q & ~(wr_status & interface_wdata[STAT_OVERRUN]));
      frame_err_q <= frame_evt |
                     (frame_err_q & ~(wr_status & interface_wdata[STAT_FRAME_ERR]));
    end
  end

  pdu_sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (push_req),
    .pop   (pop_req),
    .flush (flush),
    .wdata (shreg),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Combinational register read mux
  always_comb begin
    status_word                                 = '0;
    status_word[STAT_NOT_EMPTY]                 = !fifo_empty;
    status_word[STAT_FULL]                      = fifo_full;
    status_word[STAT_OVERRUN]                   = overrun_q;
    status_word[STAT_FRAME_ERR]                 = frame_err_q;
    status_word[STAT_COUNT_LSB +: FIFO_AW + 1]  = fifo_count;
    interface_rdata = '0;
    case (reg_sel)
      REG_RX_DATA: interface_rdata[7:0] = fifo_empty ? 8'h00 : fifo_rdata;
      REG_STATUS:  interface_rdata      = status_word;
      REG_CTRL:    interface_rdata[CTRL_ENABLE] = enable_q;
      default:     interface_rdata      = '0;
    endcase
  end

endmodule

// File: tb/tb_pdu_uart_rx.sv
// Self-checking bench for pdu_uart_rx: a queue-based model of the receive
// FIFO and flags is compared against the register port on every cycle,
// with hand-computed register values pinning the directed scenarios.
module tb_pdu_uart_rx;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 10_000;
  localparam int FIFO_AW   = 4;
  localparam int DEPTH     = 16;
  localparam int BIT_CLK   = 160;
  // start edge -> 2 sync flops -> leave idle, then 10 bit periods to stop decision
  localparam int PUSH_LAT  = 3 + 10 * BIT_CLK;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        uart_rxd  = 1'b1;
  logic [31:0] addr      = '0;
  logic [31:0] wdata     = '0;
  logic        we        = 1'b0;
  logic        re        = 1'b0;
  logic [31:0] rdata;

  pdu_uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .FIFO_AW   (FIFO_AW)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .uart_rxd        (uart_rxd),
    .interface_addr  (addr),
    .interface_rdata (rdata),
    .interface_wdata (wdata),
    .interface_we    (we),
    .interface_re    (re)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int unsigned at;
    logic [7:0]  data;
    bit          stop_ok;
  } frame_t;

  logic [7:0]  byte_q[$];
  frame_t      pend[$];
  bit          m_overrun = 1'b0;
  bit          m_ferr    = 1'b0;
  bit          m_enable  = 1'b1;
  int unsigned cyc       = 0;
  int          checks    = 0;
  int          errors    = 0;
  bit          chk_en    = 1'b0;
  bit          rand_done = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] sel);
    logic [31:0] v;
    int n;
    v = '0;
    n = byte_q.size();
    case (sel)
      2'd0: if (n > 0) v[7:0] = byte_q[0];
      2'd1: begin
        v[0]    = (n > 0);
        v[1]    = (n == DEPTH);
        v[2]    = m_overrun;
        v[3]    = m_ferr;
        v[12:8] = n[4:0];
      end
      2'd2: v[0] = m_enable;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Behavioural model: frames scheduled by the line driver land as bytes
  // or framing errors at their completion cycle; the bus acts on the FIFO.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      byte_q.delete();
      pend.delete();
      m_overrun = 1'b0;
      m_ferr    = 1'b0;
      m_enable  = 1'b1;
    end else begin : model_step
      bit         pop, push_ev, err_ev, flush;
      logic [7:0] pbyte;
      int         pre;
      cyc++;
      pre     = byte_q.size();
      pop     = re && (addr[3:2] == 2'd0) && (pre > 0);
      push_ev = 1'b0;
      err_ev  = 1'b0;
      pbyte   = 8'h00;
      if (pend.size() > 0 && pend[0].at == cyc) begin
        if (pend[0].stop_ok) push_ev = 1'b1;
        else                 err_ev  = 1'b1;
        pbyte = pend[0].data;
        void'(pend.pop_front());
      end
      flush = we && (addr[3:2] == 2'd2) && wdata[1];
      if (we && addr[3:2] == 2'd1) begin
        if (wdata[2]) m_overrun = 1'b0;
        if (wdata[3]) m_ferr    = 1'b0;
      end
      if (we && addr[3:2] == 2'd2) begin
        m_enable = wdata[0];
        if (!wdata[0]) pend.delete();
      end
      if (err_ev) m_ferr = 1'b1;
      if (flush) begin
        byte_q.delete();
      end else begin
        if (pop) void'(byte_q.pop_front());
        if (push_ev) begin
          if (pre < DEPTH || pop) byte_q.push_back(pbyte);
          else                    m_overrun = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of the selected register against the model
  always @(negedge sys_clk) begin
    if (chk_en) check($sformatf("rd_sel%0d", addr[3:2]), rdata, model_read(addr[3:2]));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic rd_check(input logic [1:0] sel, input logic [31:0] exp, input string name);
    addr = {28'h0, sel, 2'b00};
    re   = 1'b0;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] d);
    addr  = {28'h0, sel, 2'b00};
    wdata = d;
    we    = 1'b1;
    tick(1);
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic pop_byte();
    addr = '0;
    re   = 1'b1;
    tick(1);
    re   = 1'b0;
  endtask

  // Drive one 8N1 frame starting just after a clock edge
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int hold_low);
    if (m_enable) pend.push_back('{cyc + PUSH_LAT, b, stop_ok});
    uart_rxd = 1'b0;
    tick(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(BIT_CLK);
    end
    uart_rxd = stop_ok;
    tick(BIT_CLK);
    if (!stop_ok) tick(hold_low);
    uart_rxd = 1'b1;
  endtask

  initial begin
    chk_en = 1'b1;
    tick(4);
    rd_check(2'd1, 32'h0, "reset_status");
    rd_check(2'd2, 32'h1, "reset_ctrl");
    sys_rst_n = 1'b1;
    tick(2);
    rd_check(2'd0, 32'h0, "reset_rxdata");

    // single clean byte, then pop it
    send_frame(8'hA5, 1'b1, 0);
    tick(10);
    rd_check(2'd1, 32'h101, "a5_status");
    rd_check(2'd0, 32'hA5, "a5_data");
    pop_byte();
    rd_check(2'd1, 32'h0, "a5_popped");

    // 17 bytes without reading: full with overrun
    for (int i = 0; i <= 16; i++) begin
      send_frame(i[7:0], 1'b1, 0);
      tick(20);
    end
    rd_check(2'd1, 32'h1007, "fill_status");
    rd_check(2'd0, 32'h00, "fill_head");
    wr(2'd1, 32'h4);
    rd_check(2'd1, 32'h1003, "w1c_overrun");

    // pop on exactly the edge the new byte is pushed into the full FIFO
    fork
      send_frame(8'h77, 1'b1, 0);
      begin
        tick(PUSH_LAT - 1);
        addr = '0;
        re   = 1'b1;
        tick(1);
        re   = 1'b0;
      end
    join
    tick(5);
    rd_check(2'd1, 32'h1003, "same_edge_status");
    rd_check(2'd0, 32'h01, "same_edge_head");
    for (int i = 1; i < 16; i++) begin
      rd_check(2'd0, 32'(i), "drain_byte");
      pop_byte();
    end
    rd_check(2'd0, 32'h77, "tail_byte");
    pop_byte();
    rd_check(2'd1, 32'h0, "drained");

    // short glitch on an idle line
    uart_rxd = 1'b0;
    tick(60);
    uart_rxd = 1'b1;
    tick(400);
    rd_check(2'd1, 32'h0, "glitch_status");

    // framing error with the line held low afterwards
    send_frame(8'h3C, 1'b0, 500);
    tick(10);
    rd_check(2'd1, 32'h8, "ferr_status");
    wr(2'd1, 32'h8);
    rd_check(2'd1, 32'h0, "ferr_cleared");

    // flush two buffered bytes
    send_frame(8'h11, 1'b1, 0);
    tick(20);
    send_frame(8'h22, 1'b1, 0);
    tick(10);
    rd_check(2'd1, 32'h201, "preflush_status");
    wr(2'd2, 32'h3);
    rd_check(2'd1, 32'h0, "flush_status");
    rd_check(2'd2, 32'h1, "flush_ctrl");

    // disable mid-frame, then re-enable and receive
    fork
      send_frame(8'hC3, 1'b1, 0);
      begin
        tick(799);
        wr(2'd2, 32'h0);
      end
    join
    tick(50);
    rd_check(2'd2, 32'h0, "disabled_ctrl");
    rd_check(2'd1, 32'h0, "disabled_status");
    wr(2'd2, 32'h1);
    send_frame(8'h96, 1'b1, 0);
    tick(10);
    rd_check(2'd0, 32'h96, "reenabled_data");
    pop_byte();

    // reset in the middle of a data bit with a byte already buffered
    send_frame(8'h42, 1'b1, 0);
    tick(20);
    uart_rxd = 1'b0;
    tick(BIT_CLK * 3 + 40);
    sys_rst_n = 1'b0;
    uart_rxd  = 1'b1;
    tick(3);
    rd_check(2'd1, 32'h0, "midreset_status");
    rd_check(2'd2, 32'h1, "midreset_ctrl");
    rd_check(2'd0, 32'h0, "midreset_data");
    sys_rst_n = 1'b1;
    tick(20);
    send_frame(8'h5A, 1'b1, 0);
    tick(10);
    rd_check(2'd1, 32'h101, "post_reset_status");
    rd_check(2'd0, 32'h5A, "post_reset_data");
    pop_byte();

    // randomized frames against random bus traffic
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          send_frame(8'($urandom), ($urandom_range(0, 7) != 0), 0);
          tick($urandom_range(20, 200));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          addr  = $urandom();
          re    = ($urandom_range(0, 3) == 0);
          we    = (addr[3:2] != 2'd2) && ($urandom_range(0, 15) == 0);
          wdata = $urandom();
          tick(1);
        end
        re    = 1'b0;
        we    = 1'b0;
        wdata = '0;
        addr  = '0;
      end
    join
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
